// File: rtl/ipctrl.sv
// ipctrl: router input-port controller.
// Link flits land in one of two polarity-interleaved buffers. Each flit is
// XY-routed when it is written, and the route is stored with the flit. The
// buffer is freed when the granting output controller pulses its clear line.
// Optional feature: define IPCTRL_STATS_EN to get the pkt_count port, a
// saturating count of released flits.
module ipctrl #(
    parameter int DATA_W = 64,
    parameter int HOP_W  = 8,
    parameter int HX_LSB = 48,
    parameter int HY_LSB = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output logic [4:0]        req,
    output logic [DATA_W-1:0] data_out,
    input  logic [4:0]        clear_in
`ifdef IPCTRL_STATS_EN
    ,
    output logic [15:0]       pkt_count
`endif
);

    // Direction bits sit just below the MSB: data[62] = dir_x, data[61] = dir_y.
    localparam int DX_BIT = DATA_W - 2;
    localparam int DY_BIT = DATA_W - 3;

    // One-hot request encoding {W,E,N,S,PE}.
    localparam logic [4:0] REQ_W  = 5'b10000;
    localparam logic [4:0] REQ_E  = 5'b01000;
    localparam logic [4:0] REQ_N  = 5'b00100;
    localparam logic [4:0] REQ_S  = 5'b00010;
    localparam logic [4:0] REQ_PE = 5'b00001;

    logic [DATA_W-1:0] buf_even_q, buf_even_d, buf_odd_q, buf_odd_d;
    logic              full_even_q, full_even_d, full_odd_q, full_odd_d;
    logic [4:0]        req_even_q, req_even_d, req_odd_q, req_odd_d;

    logic [HOP_W-1:0]  hx, hy;
    logic [DATA_W-1:0] wr_data;
    logic [4:0]        wr_req;
    logic              wr_full, wr_en;
    logic              rd_full, rel;
    logic [4:0]        rd_req;
    logic [DATA_W-1:0] rd_buf;

    // XY routing of the incoming flit: X first, then Y, else local PE.
    always_comb begin
        hx      = data_in[HX_LSB +: HOP_W];
        hy      = data_in[HY_LSB +: HOP_W];
        wr_data = data_in;
        wr_req  = REQ_PE;
        if (hx != '0) begin
            wr_req = data_in[DX_BIT] ? REQ_E : REQ_W;
            wr_data[HX_LSB +: HOP_W] = hx - HOP_W'(1);
        end else if (hy != '0) begin
            wr_req = data_in[DY_BIT] ? REQ_N : REQ_S;
            wr_data[HY_LSB +: HOP_W] = hy - HOP_W'(1);
        end
    end

    // Polarity 0 writes odd and presents even; polarity 1 does the reverse.
    // Every output is held at 0 while reset is low.
    always_comb begin
        wr_full  = polarity ? full_even_q : full_odd_q;
        ready_in = reset & ~wr_full;
        wr_en    = send_in & ready_in;
        rd_full  = polarity ? full_odd_q : full_even_q;
        rd_req   = polarity ? req_odd_q  : req_even_q;
        rd_buf   = polarity ? buf_odd_q  : buf_even_q;
        req      = (reset && rd_full) ? rd_req : 5'b0;
        data_out = (reset && rd_full) ? rd_buf : '0;
        rel      = reset & rd_full & (|(clear_in & rd_req));
    end

    // Next state. The write target and the presented buffer always differ,
    // so a write and a release in the same cycle never conflict.
    always_comb begin
        buf_even_d  = buf_even_q;
        buf_odd_d   = buf_odd_q;
        full_even_d = full_even_q;
        full_odd_d  = full_odd_q;
        req_even_d  = req_even_q;
        req_odd_d   = req_odd_q;
        if (wr_en) begin
            if (polarity) begin
                buf_even_d  = wr_data;
                req_even_d  = wr_req;
                full_even_d = 1'b1;
            end else begin
                buf_odd_d   = wr_data;
                req_odd_d   = wr_req;
                full_odd_d  = 1'b1;
            end
        end
        if (rel) begin
            if (polarity) full_odd_d  = 1'b0;
            else          full_even_d = 1'b0;
        end
    end

    // Buffer state registers. Reset discards in-flight flits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_even_q  <= '0;
            buf_odd_q   <= '0;
            full_even_q <= 1'b0;
            full_odd_q  <= 1'b0;
            req_even_q  <= 5'b0;
            req_odd_q   <= 5'b0;
        end else begin
            buf_even_q  <= buf_even_d;
            buf_odd_q   <= buf_odd_d;
            full_even_q <= full_even_d;
            full_odd_q  <= full_odd_d;
            req_even_q  <= req_even_d;
            req_odd_q   <= req_odd_d;
        end
    end

`ifdef IPCTRL_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of released flits.
    always_comb begin
        cnt_d = cnt_q;
        if (rel && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        pkt_count = reset ? cnt_q : 16'h0;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 16'h0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_ipctrl.sv
// tb_ipctrl: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the two-slot input port.
module tb_ipctrl;

    logic        clk = 1'b0;
    logic        reset, polarity, send_in;
    logic [63:0] data_in, data_out;
    logic        ready_in;
    logic [4:0]  req, clear_in;
`ifdef IPCTRL_STATS_EN
    logic [15:0] pkt_count;
`endif

    always #5 clk = ~clk;

    ipctrl dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send_in  (send_in),
        .data_in  (data_in),
        .ready_in (ready_in),
        .req      (req),
        .data_out (data_out),
        .clear_in (clear_in)
`ifdef IPCTRL_STATS_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: slot 0 = even channel, slot 1 = odd channel.
    logic [63:0] m_buf  [2];
    logic        m_full [2];
    logic [4:0]  m_req  [2];
    int          m_cnt;

    // Values seen on the most recent sample, for directed checks.
    logic        s_ready;
    logic [4:0]  s_req;
    logic [63:0] s_dout;
    logic [15:0] s_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input bit dx, input bit dy, input int hx, input int hy);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[62] = dx;
        d[61] = dy;
        d[55:48] = 8'(hx);
        d[47:40] = 8'(hy);
        return d;
    endfunction

    // Destination and hop update from the XY rule.
    function automatic void route(input logic [63:0] d, output logic [63:0] nd, output logic [4:0] r);
        int hx, hy;
        hx = int'(d[55:48]);
        hy = int'(d[47:40]);
        nd = d;
        if (hx > 0) begin
            r = d[62] ? 5'b01000 : 5'b10000;
            nd[55:48] = 8'(hx - 1);
        end else if (hy > 0) begin
            r = d[61] ? 5'b00100 : 5'b00010;
            nd[47:40] = 8'(hy - 1);
        end else begin
            r = 5'b00001;
        end
    endfunction

    // One cycle: drive, check combinational outputs against model, advance model.
    task automatic step(input logic rst, input logic pol, input logic snd,
                        input logic [63:0] d, input logic [4:0] clr);
        int wr, rd;
        logic rel;
        logic [63:0] nd;
        logic [4:0] nr;
        @(negedge clk);
        reset = rst; polarity = pol; send_in = snd; data_in = d; clear_in = clr;
        #1;
        wr = pol ? 0 : 1;
        rd = pol ? 1 : 0;
        s_ready = ready_in; s_req = req; s_dout = data_out;
        chk("ready_in", 64'(ready_in), 64'(rst && !m_full[wr]));
        chk("req", 64'(req), 64'((rst && m_full[rd]) ? m_req[rd] : 5'b0));
        chk("data_out", data_out, (rst && m_full[rd]) ? m_buf[rd] : 64'h0);
`ifdef IPCTRL_STATS_EN
        s_cnt = pkt_count;
        chk("pkt_count", 64'(pkt_count), rst ? 64'(m_cnt) : 64'h0);
`else
        s_cnt = 16'h0;
`endif
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_full[i] = 1'b0; m_buf[i] = '0; m_req[i] = '0;
            end
            m_cnt = 0;
        end else begin
            rel = m_full[rd] && ((clr & m_req[rd]) != 5'b0);
            if (snd && !m_full[wr]) begin
                route(d, nd, nr);
                m_buf[wr] = nd; m_req[wr] = nr; m_full[wr] = 1'b1;
            end
            if (rel) begin
                m_full[rd] = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    logic [63:0] fa, fb, fc, fd, fe, ff;
    logic        pol;
    logic [4:0]  clr;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0; m_buf[i] = '0; m_req[i] = '0;
        end
        m_cnt = 0;
        reset = 1'b0; polarity = 1'b0; send_in = 1'b0; data_in = '0; clear_in = '0;

        // 1: reset, then ready with polarity 0
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h1F);
        step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h1F);
        chk("rst_ready", 64'(s_ready), 64'h0);
        chk("rst_req", 64'(s_req), 64'h0);
        step(1, 0, 0, '0, '0);
        chk("ready_after_rst", 64'(s_ready), 64'h1);

        // 2: east flit, hx 2 -> 1, then cleared
        fa = mk(1, 0, 2, 0);
        step(1, 0, 1, fa, '0);
        step(1, 1, 0, '0, 5'b01000);
        chk("east_req", 64'(s_req), 64'b01000);
        chk("east_hx", 64'(s_dout[55:48]), 64'd1);
        step(1, 0, 0, '0, '0);
        chk("odd_freed", 64'(s_ready), 64'h1);
        step(1, 1, 0, '0, '0);
        chk("odd_empty_req", 64'(s_req), 64'h0);

        // 3: PE flit and south flit
        fb = mk(0, 1, 0, 0);
        step(1, 0, 1, fb, '0);
        step(1, 1, 0, '0, 5'b00001);
        chk("pe_req", 64'(s_req), 64'b00001);
        chk("pe_data", s_dout, fb);
        fc = mk(1, 0, 0, 3);
        step(1, 0, 1, fc, '0);
        step(1, 1, 0, '0, 5'b00010);
        chk("south_req", 64'(s_req), 64'b00010);
        chk("south_hy", 64'(s_dout[47:40]), 64'd2);
        step(1, 0, 0, '0, '0);
`ifdef IPCTRL_STATS_EN
        chk("cnt_three", 64'(s_cnt), 64'd3);
`endif

        // 4: held odd flit blocks further writes
        fd = mk(0, 0, 1, 5);
        step(1, 0, 1, fd, '0);
        step(1, 1, 0, '0, '0);
        chk("west_req", 64'(s_req), 64'b10000);
        fe = mk(1, 1, 0, 0);
        step(1, 0, 1, fe, '0);
        chk("blocked_ready", 64'(s_ready), 64'h0);
        step(1, 1, 0, '0, '0);
        chk("held_req", 64'(s_req), 64'b10000);
        chk("held_hx", 64'(s_dout[55:48]), 64'd0);
        chk("held_hy", 64'(s_dout[47:40]), 64'd5);

        // 5: mismatched clear ignored; then write + release together
        step(1, 1, 0, '0, 5'b01000);
        step(1, 1, 0, '0, '0);
        chk("wrong_clear_req", 64'(s_req), 64'b10000);
        ff = mk(1, 1, 0, 1);
        step(1, 1, 1, ff, 5'b10000);
        step(1, 0, 0, '0, '0);
        chk("same_cycle_write", 64'(s_req), 64'b00100);
        chk("same_cycle_ready", 64'(s_ready), 64'h1);
        step(1, 1, 0, '0, '0);
        chk("same_cycle_release", 64'(s_req), 64'h0);

        // 6: reset mid-flight with a matching clear
        step(1, 0, 1, fa, '0);
        step(0, 1, 0, '0, 5'b11111);
        step(1, 1, 0, '0, '0);
        chk("midrst_req", 64'(s_req), 64'h0);
`ifdef IPCTRL_STATS_EN
        chk("midrst_cnt", 64'(s_cnt), 64'h0);
`endif

        // Randomized traffic
        pol = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) != 0) pol = ~pol;
            if ($urandom_range(0, 1) == 1) clr = m_req[pol ? 1 : 0];
            else clr = 5'($urandom);
            if ($urandom_range(0, 3) == 0) clr = 5'b0;
            step($urandom_range(0, 99) != 0, pol, $urandom_range(0, 9) < 7,
                 mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2), $urandom_range(0, 2)),
                 clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
